uart_autobaud: RTL
==================

// Module: uart_autobaud
//
// PURPOSE
// Baud-rate configuration controller for the UART receiver. It measures low-pulse widths
// on the raw RX line while the host sends a sync pattern (0x55 bytes / 0x5555 words).
// Once SYNC_MATCHES consecutive widths agree and the line has gone idle, it drives the
// registered prescaler into the receiver and releases the receiver from reset.
// Sits between the RX pin and the receiver's i_baudrate_prescaler / i_reset.
//
// PARAMETERS
// DEFAULT_PRESCALER  16'd103  prescaler driven before the first lock
// SYNC_MATCHES       3        consecutive agreeing pulses required to lock (1..15)
// MIN_WIDTH          4        pulses shorter than this (cycles) are discarded as glitches
// TOL_SHIFT          3        tolerance = ref >> TOL_SHIFT cycles
// GUARD_SHIFT        5        idle guard = ref << GUARD_SHIFT cycles of continuous high
//
// PORTS
// i_clk                 in   1   clock
// i_reset               in   1   synchronous, active-high reset
// i_uart_rx             in   1   raw asynchronous RX pin
// i_relock              in   1   1-cycle pulse: drop lock, re-measure
// o_baudrate_prescaler  out  16  registered prescaler to receiver (bit period = value+1)
// o_locked              out  1   high while the prescaler is valid and the receiver is enabled
// o_rx_reset            out  1   high holds the receiver in reset
//
// BEHAVIOUR
// - Reset: o_baudrate_prescaler=DEFAULT_PRESCALER, o_locked=0, o_rx_reset=1.
//   State=HUNT, match count=0. Reset wins over every other input in any state.
// - RX passes a 3-flop synchroniser; all edge detection uses the synchronised line.
// - States:
//   HUNT:    wait for a falling edge -> MEASURE, width counter=1.
//   MEASURE: width += 1 per low cycle, saturating at 16'hFFFF.
//            On a rising edge -> COMPARE. While saturated, stay until the rising edge.
//   COMPARE (1 cycle), on width w:
//            * w<MIN_WIDTH or w==16'hFFFF: discard, matches=0.
//            * matches==0: ref=w, matches=1.
//            * |w-ref| <= ref>>TOL_SHIFT: matches+1 (ref unchanged).
//            * otherwise: ref=w, matches=1.
//            If matches reaches SYNC_MATCHES -> SETTLE; else -> HUNT.
//   SETTLE:  count consecutive high cycles; any low cycle clears the count.
//            When count == ref<<GUARD_SHIFT (24-bit compare): prescaler<=ref-1, -> LOCKED.
//   LOCKED:  o_locked=1 and o_rx_reset=0, both starting the cycle after the guard is met.
//            The line is ignored. Exit only via i_relock or reset.
// - i_relock in any state -> HUNT next cycle: matches=0, o_locked=0, o_rx_reset=1.
//   o_baudrate_prescaler keeps its last locked value.
// - o_baudrate_prescaler changes only on entry to LOCKED, never mid-frame.
// - Arithmetic: 16-bit unsigned; |w-ref| is computed without wrap (larger minus smaller).
//
// TESTING
// 1 Reset: 0x55 bytes at 104 clk/bit, then idle >=3328 cycles
//   -> prescaler=103, o_locked=1, o_rx_reset=0; receiver decodes a following 0xA5 correctly.
// 2 Tolerance: low pulses of 104,110,98 -> lock with prescaler=103.
//   Pulses 104,130,130,130 -> ref restarts at 130, lock with prescaler=129.
// 3 Glitch: a 2-cycle low pulse between two 104-cycle pulses -> matches cleared, no lock
//   until 3 further good pulses.
// 4 Stuck low for 70000 cycles -> saturate, discard; no lock; no wrap to a small width.
// 5 Relock: in LOCKED pulse i_relock, send sync at 52 clk/bit
//   -> o_locked low next cycle, prescaler holds 103, then relocks to 51.
// 6 Reset asserted mid-MEASURE and in SETTLE -> all outputs return to reset values next cycle;
//   a subsequent sync sequence locks normally.

Source files
------------

// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures low-pulse widths of a 0x55 sync pattern on the RX pin,
// locks once enough widths agree and the line idles, then releases the receiver.
module uart_autobaud #(
  parameter logic [15:0] DEFAULT_PRESCALER = 16'd103,
  parameter int unsigned SYNC_MATCHES      = 3,
  parameter int unsigned MIN_WIDTH         = 4,
  parameter int unsigned TOL_SHIFT         = 3,
  parameter int unsigned GUARD_SHIFT       = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_uart_rx,
  input  logic        i_relock,
  output logic [15:0] o_baudrate_prescaler,
  output logic        o_locked,
  output logic        o_rx_reset
);

  localparam logic [15:0] MinW  = 16'(MIN_WIDTH);
  localparam logic [3:0]  SyncN = 4'(SYNC_MATCHES);

  typedef enum logic [2:0] {
    HUNT,
    MEASURE,
    COMPARE,
    SETTLE,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [15:0] width_q, width_d;
  logic [15:0] ref_width_q, ref_width_d;
  logic [3:0]  matches_q, matches_d;
  logic [23:0] settle_q, settle_d;
  logic [15:0] presc_q, presc_d;
  logic        locked_q, locked_d;
  logic        rx_reset_q, rx_reset_d;

  logic        rx_sync;
  logic        rx_fall;
  logic [15:0] diff;
  logic [15:0] tol;
  logic [23:0] guard;

  assign rx_sync = sync_q[2];
  assign rx_fall = rx_prev_q & ~rx_sync;

  assign o_baudrate_prescaler = presc_q;
  assign o_locked             = locked_q;
  assign o_rx_reset           = rx_reset_q;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[1:0], i_uart_rx};
    rx_prev_d   = rx_sync;
    width_d     = width_q;
    ref_width_d = ref_width_q;
    matches_d   = matches_q;
    settle_d    = settle_q;
    presc_d     = presc_q;
    locked_d    = locked_q;
    rx_reset_d  = rx_reset_q;

    // Larger minus smaller, so the distance never wraps.
    diff  = (width_q > ref_width_q) ? (width_q - ref_width_q) : (ref_width_q - width_q);
    tol   = ref_width_q >> TOL_SHIFT;
    guard = 24'(ref_width_q) << GUARD_SHIFT;

    case (state_q)
      HUNT: begin
        if (rx_fall) begin
          state_d = MEASURE;
          width_d = 16'd1;
        end
      end
      MEASURE: begin
        if (rx_sync) begin
          state_d = COMPARE;
        end else if (width_q != '1) begin
          width_d = width_q + 16'd1;
        end
      end
      COMPARE: begin
        state_d = HUNT;
        if ((width_q < MinW) || (width_q == '1)) begin
          matches_d = '0;
        end else if ((matches_q == '0) || (diff > tol)) begin
          ref_width_d = width_q;
          matches_d   = 4'd1;
        end else begin
          matches_d = matches_q + 4'd1;
        end
        if (matches_d == SyncN) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == guard) begin
          presc_d    = ref_width_q - 16'd1;
          locked_d   = 1'b1;
          rx_reset_d = 1'b0;
          state_d    = LOCKED;
        end else begin
          settle_d = rx_sync ? (settle_q + 24'd1) : '0;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // Relock overrides any state; the prescaler keeps its last locked value.
    if (i_relock) begin
      state_d    = HUNT;
      matches_d  = '0;
      locked_d   = 1'b0;
      rx_reset_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= HUNT;
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      width_q     <= '0;
      ref_width_q <= '0;
      matches_q   <= '0;
      settle_q    <= '0;
      presc_q     <= DEFAULT_PRESCALER;
      locked_q    <= 1'b0;
      rx_reset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      width_q     <= width_d;
      ref_width_q <= ref_width_d;
      matches_q   <= matches_d;
      settle_q    <= settle_d;
      presc_q     <= presc_d;
      locked_q    <= locked_d;
      rx_reset_q  <= rx_reset_d;
    end
  end

endmodule
